// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencing (load-use stall, branch flush, data-memory wait freeze)
// Optional feature macro: PIPE_MEM_TIMEOUT_EN (memory-wait timeout with sticky timeout_o)
// Ports:
//   clk_i, rst_n_i                      clock, synchronous active-low reset
//   idex_memread_i, idex_rt_i           load in EX and its destination register
//   ifid_rs_i, ifid_rt_i                source registers of the instruction in ID
//   branch_taken_i                      branch resolved taken in ID
//   exmem_memaccess_i, dmem_ack_i       memory access in MEM and its completion
//   dmem_req_o                          data memory request
//   pc_write_o .. exmem_write_o         stage-register load enables
//   ifid_flush_o, idex_bubble_o         IF/ID flush, ID/EX control bubble
//   memwb_bubble_o                      kill RegWrite/MemtoReg into MEM/WB
//   stall_cnt_o                         saturating stalled-cycle count
//   timeout_o                           sticky memory-timeout flag
module pipe_hazard_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   idex_memread_i,
  input  logic [4:0]             idex_rt_i,
  input  logic [4:0]             ifid_rs_i,
  input  logic [4:0]             ifid_rt_i,
  input  logic                   branch_taken_i,
  input  logic                   exmem_memaccess_i,
  input  logic                   dmem_ack_i,
  output logic                   dmem_req_o,
  output logic                   pc_write_o,
  output logic                   ifid_write_o,
  output logic                   idex_write_o,
  output logic                   exmem_write_o,
  output logic                   ifid_flush_o,
  output logic                   idex_bubble_o,
  output logic                   memwb_bubble_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   timeout_o
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_nx, st;
  logic hazard, mem_stall, lu, hit;
  // While reset is asserted the controller decodes as if in RUN.
  assign st = rst_n_i ? state : RUN;
  always_comb begin
    hazard = idex_memread_i && idex_rt_i != 5'd0 && (idex_rt_i == ifid_rs_i || idex_rt_i == ifid_rt_i);
    mem_stall = st == RUN ? exmem_memaccess_i && !dmem_ack_i : !dmem_ack_i && !hit;
    lu = hazard && !mem_stall;
    dmem_req_o = st == MEM_WAIT || exmem_memaccess_i;
    pc_write_o = !mem_stall && !lu;
    ifid_write_o = !mem_stall && !lu;
    idex_write_o = !mem_stall;
    exmem_write_o = !mem_stall;
    ifid_flush_o = branch_taken_i && !mem_stall && !lu;
    idex_bubble_o = lu;
    // A timeout advances the pipeline but the missing load data must not reach WB.
    memwb_bubble_o = mem_stall || hit;
    state_nx = mem_stall ? MEM_WAIT : RUN;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= RUN;
      stall_cnt_o <= '0;
    end else begin
      state <= state_nx;
      if ((mem_stall || hazard) && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`ifdef PIPE_MEM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WW-1:0] wcnt;
  logic to_q;
  // The TIMEOUT_CYCLES-th cycle spent in MEM_WAIT stands in for the ack.
  assign hit = st == MEM_WAIT && !dmem_ack_i && wcnt == WW'(TIMEOUT_CYCLES - 1);
  assign timeout_o = to_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wcnt <= '0;
      to_q <= 1'b0;
    end else begin
      wcnt <= (st == MEM_WAIT && !dmem_ack_i && !hit) ? wcnt + 1'b1 : '0;
      if (hit) to_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign hit = 1'b0;
  assign timeout_o = 1'b0;
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage CPU: decides each cycle whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold, bubble or flush. Covers load-use hazards, branch-taken flushes, and a variable-latency data-memory handshake. While memory is waiting, the MEM/WB register loads a bubble so WB never sees a stale write. Sits beside the hazard/forwarding logic and drives the write/bubble enables of every pipeline register.

## Interface
- STALL_CNT_W, 16, width of saturating stall-cycle counter
- TIMEOUT_CYCLES, 64, MEM_WAIT cycles before timeout (only with PIPE_MEM_TIMEOUT_EN)

- clk_i  input  1  clock; all state updates on posedge
- rst_n_i  input  1  synchronous active-low reset, sampled on posedge clk_i
- idex_memread_i  input  1  instruction in EX is a load
- idex_rt_i  input  5  destination register of that load
- ifid_rs_i, ifid_rt_i  input  5 each  source registers of instruction in ID
- branch_taken_i  input  1  branch resolved taken in ID
- exmem_memaccess_i  input  1  instruction in MEM is a load or store
- dmem_ack_i  input  1  data memory completes access this cycle
- dmem_req_o  output  1  data memory request
- pc_write_o, ifid_write_o, idex_write_o, exmem_write_o  output  1 each  stage-register load enables
- ifid_flush_o  output  1  load NOP into IF/ID
- idex_bubble_o  output  1  zero ID/EX control bits
- memwb_bubble_o  output  1  force RegWrite=0, MemtoReg=0 into MEM/WB
- stall_cnt_o  output  STALL_CNT_W  saturating count of stalled cycles
- timeout_o  output  1  sticky memory-timeout flag

## Operation
- FSM states: RUN, MEM_WAIT.
- Memory stall (highest priority):
  - In RUN with exmem_memaccess_i=1: dmem_req_o=1.
  - If dmem_ack_i=1 the same cycle: no stall, stay RUN.
  - Otherwise mem_stall: go to MEM_WAIT.
- In MEM_WAIT:
  - dmem_req_o=1.
  - mem_stall holds until dmem_ack_i=1.
  - On the ack cycle, mem_stall=0 and the FSM returns to RUN.
- mem_stall outputs:
  - pc_write_o, ifid_write_o, idex_write_o, exmem_write_o = 0.
  - memwb_bubble_o=1.
  - ifid_flush_o=0 and idex_bubble_o=0; no hazard action is taken while frozen.
- Load-use stall (RUN, no mem_stall):
  - Condition: idex_memread_i=1, idex_rt_i≠0, and (idex_rt_i==ifid_rs_i or idex_rt_i==ifid_rt_i).
  - Outputs: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; idex_write_o and exmem_write_o stay 1.
  - Lasts exactly one cycle, because the bubble clears idex_memread_i.
- Branch flush: ifid_flush_o = branch_taken_i, only when neither stall is active. A branch waiting on a load is flushed after its stall ends.
- Default outputs (no stall): all write enables 1; ifid_flush_o, idex_bubble_o, memwb_bubble_o = 0.
- stall_cnt_o:
  - Increments on every cycle where mem_stall or load-use is active.
  - Saturates at all-ones; no wrap.
  - A cycle with both active counts once.

## Timing
- Control outputs are combinational from state and inputs; same-cycle effect on the pipeline registers.
- stall_cnt_o, timeout_o and the state are registered.
- Reset (rst_n_i=0 at posedge): state=RUN, stall_cnt_o=0, timeout_o=0, wait counter=0.
- During reset, outputs follow RUN decode of the current inputs.
- Reset in MEM_WAIT: next cycle is RUN; dmem_req_o follows exmem_memaccess_i.
- Zero-wait memory: no bubble, no stall cycle counted.
- N-cycle memory (ack N cycles after the request first asserts): exactly N stall cycles and N MEM/WB bubbles.
- Simultaneous load-use and mem_stall: mem_stall wins; the load-use stall occurs on the first unfrozen cycle.

## Configuration
- PIPE_MEM_TIMEOUT_EN defined:
  - A wait counter (clog2(TIMEOUT_CYCLES)+1 bits) counts cycles spent in MEM_WAIT.
  - Cleared on entry to MEM_WAIT and on exit from it.
  - If it reaches TIMEOUT_CYCLES without an ack: that cycle is treated as the ack (pipeline advances, memwb_bubble_o=1), the FSM returns to RUN, and timeout_o sets.
  - timeout_o stays 1 until reset.
- PIPE_MEM_TIMEOUT_EN undefined: no counter, timeout_o tied 0, MEM_WAIT persists indefinitely.

## Test plan
- Load-use stall: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5, memory acks immediately.
  - Required: one cycle with pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - Required: stall_cnt_o 0→1.
- Register 0 and non-matching cases: idex_rt_i=0 matching ifid_rs_i=0, then idex_rt_i=7 with ifid_rs_i=3, ifid_rt_i=4.
  - Required: no stall in either case; all write enables stay 1.
- Three-cycle memory: exmem_memaccess_i=1, dmem_ack_i rises 3 cycles after the request.
  - Required: 3 cycles with all write enables 0 and memwb_bubble_o=1, then RUN.
  - Required: stall_cnt_o=3.
- Branch during freeze: branch_taken_i=1 during a mem_stall.
  - Required: ifid_flush_o=0 while frozen, 1 on the first unfrozen cycle.
- Reset mid-wait: rst_n_i=0 in MEM_WAIT with stall_cnt_o=9.
  - Required: next cycle state RUN, stall_cnt_o=0, timeout_o=0.
- With PIPE_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never arrives.
  - Required: pipeline advances after 4 cycles, timeout_o=1 and sticky.
  - Required: timeout_o stays 0 in the macro-off build.
